// File: rtl/vga_pattern_sequencer_if.sv
// rtl/vga_pattern_sequencer_if.sv - pixel position, control and RGB bundle for the pattern sequencer
//
// Purpose: groups everything between the pattern generators / VGA timing stage
// and the sequencer, so the sequencer exposes only clock, reset and this bundle.
// Signals:
//   i_px, i_py          current pixel coordinate
//   i_next, i_auto,     manual advance request, dwell auto-advance enable,
//   i_hold              freeze on current pattern
//   i_red/green/blue    pattern k colour at [3k+2:3k]
//   o_red/green/blue    selected colour, one cycle latency
//   o_sel               active pattern index
//   o_patReset          one-hot restart pulse for the newly selected pattern
//   o_busy              high while blanking or switching
// master drives the inputs (generators/timing side), slave is the sequencer.
interface vga_pattern_sequencer_if #(
  parameter int NUM_PATTERNS = 3
) ();
  logic [9:0]                  i_px;
  logic [9:0]                  i_py;
  logic                        i_next;
  logic                        i_auto;
  logic                        i_hold;
  logic [3*NUM_PATTERNS-1:0]   i_red;
  logic [3*NUM_PATTERNS-1:0]   i_green;
  logic [3*NUM_PATTERNS-1:0]   i_blue;
  logic [2:0]                  o_red;
  logic [2:0]                  o_green;
  logic [2:0]                  o_blue;
  logic [1:0]                  o_sel;
  logic [NUM_PATTERNS-1:0]     o_patReset;
  logic                        o_busy;

  modport master (
    output i_px, i_py, i_next, i_auto, i_hold, i_red, i_green, i_blue,
    input  o_red, o_green, o_blue, o_sel, o_patReset, o_busy
  );

  modport slave (
    input  i_px, i_py, i_next, i_auto, i_hold, i_red, i_green, i_blue,
    output o_red, o_green, o_blue, o_sel, o_patReset, o_busy
  );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - selects which pattern generator drives the VGA RGB outputs
//
// Purpose: shows one of NUM_PATTERNS generators; advances on a manual request
// or after DWELL_MS of auto dwell, switching only at frame start with
// BLANK_FRAMES black frames in between, and pulses the new pattern's restart.
// Ports:
//   i_clk     pixel clock, one pixel per cycle
//   i_reset   synchronous, active-high
//   bus       vga_pattern_sequencer_if slave (pixel position, controls,
//             pattern colours in, selected colour / sel / restart / busy out)
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS = 3,
  parameter int CLKS_PER_MS  = 25_000,
  parameter int DWELL_MS     = 5_000,
  parameter int BLANK_FRAMES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  vga_pattern_sequencer_if.slave bus
);
  localparam int               MS_W      = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [MS_W-1:0]  MS_LAST   = MS_W'(CLKS_PER_MS - 1);
  localparam logic [15:0]      DWELL_END = 16'(DWELL_MS);
  localparam logic [3:0]       BLANK_END = 4'(BLANK_FRAMES);
  localparam logic [1:0]       SEL_LAST  = 2'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {ST_SHOW, ST_BLANK, ST_SWITCH} state_t;

  state_t                  state_q, state_d;
  logic                    origin_q, origin_d;
  logic [MS_W-1:0]         ms_q, ms_d;
  logic [15:0]             dwell_q, dwell_d;
  logic [3:0]              blank_q, blank_d;
  logic                    pending_q, pending_d;
  logic                    expired_q, expired_d;
  logic [1:0]              sel_q, sel_d;
  logic [NUM_PATTERNS-1:0] pat_reset_q, pat_reset_d;
  logic [2:0]              red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                    busy_q, busy_d;

  logic                    at_origin;
  logic                    fs;
  logic [2:0]              sel_red, sel_green, sel_blue;

  // Rising edge of the origin condition: a timing stage that lingers on (0,0)
  // still yields a single frame-start strobe.
  assign at_origin = (bus.i_px == 10'd0) && (bus.i_py == 10'd0);
  assign fs        = at_origin && !origin_q;

  always_comb begin
    sel_red   = '0;
    sel_green = '0;
    sel_blue  = '0;
    for (int k = 0; k < NUM_PATTERNS; k++) begin
      if (sel_q == 2'(k)) begin
        sel_red   = bus.i_red[3*k +: 3];
        sel_green = bus.i_green[3*k +: 3];
        sel_blue  = bus.i_blue[3*k +: 3];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    origin_d    = at_origin;
    ms_d        = ms_q;
    dwell_d     = dwell_q;
    blank_d     = blank_q;
    pending_d   = pending_q;
    expired_d   = expired_q;
    sel_d       = sel_q;
    pat_reset_d = '0;
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;

    case (state_q)
      ST_SHOW: begin
        red_d   = sel_red;
        green_d = sel_green;
        blue_d  = sel_blue;
        if (bus.i_next) pending_d = 1'b1;
        if (!bus.i_auto) begin
          ms_d      = '0;
          dwell_d   = '0;
          expired_d = 1'b0;
        end else if (!bus.i_hold) begin
          if (dwell_q == DWELL_END) expired_d = 1'b1;
          if (ms_q == MS_LAST) begin
            ms_d = '0;
            // Saturate so a long-expired dwell never wraps back to zero.
            if (dwell_q != DWELL_END) dwell_d = dwell_q + 16'd1;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
        if (fs && (pending_q || expired_q) && !bus.i_hold) begin
          state_d = ST_BLANK;
          blank_d = '0;
        end
      end
      ST_BLANK: begin
        if (fs) begin
          blank_d = blank_q + 4'd1;
          if (blank_q + 4'd1 == BLANK_END) state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        sel_d       = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
        pat_reset_d = NUM_PATTERNS'(1) << sel_d;
        pending_d   = 1'b0;
        expired_d   = 1'b0;
        dwell_d     = '0;
        ms_d        = '0;
        state_d     = ST_SHOW;
      end
      default: state_d = ST_SHOW;
    endcase

    busy_d = (state_d != ST_SHOW);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_SHOW;
      origin_q    <= 1'b0;
      ms_q        <= '0;
      dwell_q     <= '0;
      blank_q     <= '0;
      pending_q   <= 1'b0;
      expired_q   <= 1'b0;
      sel_q       <= '0;
      pat_reset_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      ms_q        <= ms_d;
      dwell_q     <= dwell_d;
      blank_q     <= blank_d;
      pending_q   <= pending_d;
      expired_q   <= expired_d;
      sel_q       <= sel_d;
      pat_reset_q <= pat_reset_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_red      = red_q;
  assign bus.o_green    = green_q;
  assign bus.o_blue     = blue_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_patReset = pat_reset_q;
  assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb/tb_vga_pattern_sequencer.sv - scoreboard bench for vga_pattern_sequencer
module tb_vga_pattern_sequencer;
  localparam int NP        = 3;
  localparam int CPM       = 4;
  localparam int DW        = 3;
  localparam int BF        = 1;
  localparam int FW        = 8;
  localparam int FH        = 4;
  localparam int RW        = 3 * NP;
  // Expired is seen once CPM*DW active dwell cycles have elapsed plus the
  // cycle in which the full dwell is observed.
  localparam int EXP_AFTER = CPM * DW + 1;
  localparam int M_SHOW    = 0;
  localparam int M_BLANK   = 1;
  localparam int M_SWITCH  = 2;

  typedef struct {
    logic [2:0]    r;
    logic [2:0]    g;
    logic [2:0]    b;
    logic [1:0]    sel;
    logic [NP-1:0] pr;
    logic          busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fixed_rgb = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   px = 0;
  int   py = 0;
  exp_t sb[$];

  int   m_mode = M_SHOW;
  int   m_sel = 0;
  int   m_n = 0;
  int   m_blanked = 0;
  logic m_pending = 1'b0;
  logic m_prev_origin = 1'b0;

  always #5 clk = ~clk;

  vga_pattern_sequencer_if #(.NUM_PATTERNS(NP)) bus ();

  vga_pattern_sequencer #(
    .NUM_PATTERNS(NP),
    .CLKS_PER_MS (CPM),
    .DWELL_MS    (DW),
    .BLANK_FRAMES(BF)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Reference model: one update per clock edge, expressed as frames shown,
  // active dwell cycles accumulated and requests outstanding.
  initial begin : model
    exp_t e;
    logic origin, fs, go;
    forever begin
      @(posedge clk);
      cyc++;
      e.pr = '0;
      e.r  = '0;
      e.g  = '0;
      e.b  = '0;
      if (rst) begin
        m_mode        = M_SHOW;
        m_sel         = 0;
        m_n           = 0;
        m_pending     = 1'b0;
        m_blanked     = 0;
        m_prev_origin = 1'b0;
      end else begin
        origin        = (bus.i_px == 10'd0) && (bus.i_py == 10'd0);
        fs            = origin && !m_prev_origin;
        m_prev_origin = origin;
        if (m_mode == M_SHOW) begin
          e.r = bus.i_red[3*m_sel +: 3];
          e.g = bus.i_green[3*m_sel +: 3];
          e.b = bus.i_blue[3*m_sel +: 3];
        end
        case (m_mode)
          M_SHOW: begin
            go = fs && (m_pending || (m_n >= EXP_AFTER)) && !bus.i_hold;
            if (bus.i_next) m_pending = 1'b1;
            if (!bus.i_auto) m_n = 0;
            else if (!bus.i_hold) m_n++;
            if (go) begin
              m_mode    = M_BLANK;
              m_blanked = 0;
            end
          end
          M_BLANK: begin
            if (fs) begin
              m_blanked++;
              if (m_blanked == BF) m_mode = M_SWITCH;
            end
          end
          default: begin
            m_sel     = (m_sel + 1) % NP;
            e.pr      = NP'(1) << m_sel;
            m_pending = 1'b0;
            m_n       = 0;
            m_mode    = M_SHOW;
          end
        endcase
      end
      e.sel  = 2'(m_sel);
      e.busy = (m_mode != M_SHOW);
      sb.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("o_red", 32'(bus.o_red), 32'(e.r));
        chk("o_green", 32'(bus.o_green), 32'(e.g));
        chk("o_blue", 32'(bus.o_blue), 32'(e.b));
        chk("o_sel", 32'(bus.o_sel), 32'(e.sel));
        chk("o_patReset", 32'(bus.o_patReset), 32'(e.pr));
        chk("o_busy", 32'(bus.o_busy), 32'(e.busy));
      end
    end
  end

  task automatic step(input logic nxt, input logic au, input logic hd, input logic rs);
    @(negedge clk);
    rst        = rs;
    bus.i_next = nxt;
    bus.i_auto = au;
    bus.i_hold = hd;
    if (fixed_rgb) begin
      bus.i_red   = {3'd3, 3'd2, 3'd1};
      bus.i_green = {3'd3, 3'd2, 3'd1};
      bus.i_blue  = {3'd3, 3'd2, 3'd1};
    end else begin
      bus.i_red   = RW'($urandom);
      bus.i_green = RW'($urandom);
      bus.i_blue  = RW'($urandom);
    end
    // Occasionally repeat a pixel so the origin lasts two cycles.
    if ($urandom_range(7) != 0) begin
      px++;
      if (px == FW) begin
        px = 0;
        py = (py + 1) % FH;
      end
    end
    bus.i_px = 10'(px);
    bus.i_py = 10'(py);
  endtask

  initial begin : stimulus
    logic au, hd;
    int   guard;
    bus.i_px    = '0;
    bus.i_py    = '0;
    bus.i_next  = 1'b0;
    bus.i_auto  = 1'b0;
    bus.i_hold  = 1'b0;
    bus.i_red   = '0;
    bus.i_green = '0;
    bus.i_blue  = '0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Auto dwell only: selection walks 0,1,2,0...
    repeat (500) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Manual pulses with auto off.
    for (int i = 0; i < 600; i++) step($urandom_range(40) == 0, 1'b0, 1'b0, 1'b0);

    // Request under hold stays pending until hold drops.
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (120) step(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (80) step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // i_next held high throughout: one advance per show/blank/switch round.
    repeat (400) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Fixed per-pattern colours.
    fixed_rgb = 1'b1;
    for (int i = 0; i < 400; i++) step($urandom_range(30) == 0, 1'b1, 1'b0, 1'b0);
    fixed_rgb = 1'b0;

    // Reset in the middle of a blank frame.
    guard = 0;
    while (m_mode != M_BLANK && guard < 300) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_blank_before_reset", 32'(m_mode), 32'(M_BLANK));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Mixed random controls including sporadic resets.
    au = 1'b1;
    hd = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(199) == 0) au = ~au;
      if ($urandom_range(149) == 0) hd = ~hd;
      step($urandom_range(39) == 0, au, hd, $urandom_range(599) == 0);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
